// File: rtl/jtkunio_gfx_pkg.sv
// Shared types and helpers for the Kunio graphics ROM arbiter.
// Client indices, FSM states and the grant picker live here.
package jtkunio_gfx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DST
  } state_t;

  localparam logic [1:0] CHAR = 2'd0;
  localparam logic [1:0] SCR  = 2'd1;
  localparam logic [1:0] OBJ  = 2'd2;

  localparam int SDRAM_AW = 22;
  localparam int TAG_W    = 18;

  // First pending client at or after ptr, wrapping obj->char
  function automatic logic [1:0] pick(
    input logic [2:0] pend,
    input logic [1:0] ptr
  );
    logic [5:0] dbl;
    logic [2:0] rot;
    logic [2:0] sum;
    dbl = {pend, pend};
    rot = dbl[ptr +: 3];
    if (rot[0])
      sum = {1'b0, ptr};
    else if (rot[1])
      sum = {1'b0, ptr} + 3'd1;
    else
      sum = {1'b0, ptr} + 3'd2;
    if (sum >= 3'd3)
      sum = sum - 3'd3;
    return sum[1:0];
  endfunction

endpackage

// File: rtl/jtkunio_gfx_slot.sv
// One-entry tag/data cache for a single graphics ROM client.
// hit is combinational on the live client address.
module jtkunio_gfx_slot
  import jtkunio_gfx_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          wr,
  input  logic [AW-1:0] wr_tag,
  input  logic [31:0]   wr_data,
  output logic          hit,
  output logic [31:0]   data
);

  logic          valid;
  logic [AW-1:0] tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (wr) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end
  end

  assign hit = cs & valid & (tag == addr);

endmodule

// File: rtl/jtkunio_gfx_arb.sv
// Char/scroll/object ROM arbiter onto one SDRAM read port.
// Define JTKUNIO_GFX_RR_EN for round-robin grants, else fixed priority.
module jtkunio_gfx_arb
  import jtkunio_gfx_pkg::*;
#(
  parameter logic [21:0] CHAR_OFFSET = 22'h0,
  parameter logic [21:0] SCR_OFFSET  = 22'h4000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h24000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        char_cs,
  input  logic [13:0] char_addr,
  output logic [31:0] char_data,
  output logic        char_ok,
  input  logic        scr_cs,
  input  logic [16:0] scr_addr,
  output logic [31:0] scr_data,
  output logic        scr_ok,
  input  logic        obj_cs,
  input  logic [17:0] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_dst,
  input  logic [31:0] sdram_data
);

  state_t state, state_nx;

  logic [1:0]          sel, sel_nx, pick_idx;
  logic [TAG_W-1:0]    ftag, ftag_nx;
  logic [SDRAM_AW-1:0] addr_nx, base;
  logic                req_nx;
  logic [2:0]          cs, hit, pend, wr;
  logic                dst_ev;

  logic [2:0][TAG_W-1:0] cli_addr;

  assign cli_addr[CHAR] = TAG_W'(char_addr);
  assign cli_addr[SCR]  = TAG_W'(scr_addr);
  assign cli_addr[OBJ]  = obj_addr;

  assign cs   = {obj_cs, scr_cs, char_cs};
  assign pend = cs & ~hit;

`ifdef JTKUNIO_GFX_RR_EN
  logic [1:0] ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= CHAR;
    else if (state == IDLE && |pend)
      ptr <= (pick_idx == OBJ) ? CHAR : pick_idx + 2'd1;
  end

  assign pick_idx = pick(pend, ptr);
`else
  assign pick_idx = pick(pend, CHAR);
`endif

  always_comb begin
    base = OBJ_OFFSET;
    unique case (pick_idx)
      CHAR:    base = CHAR_OFFSET;
      SCR:     base = SCR_OFFSET;
      default: base = OBJ_OFFSET;
    endcase
  end

  // dst together with ack counts as the data event
  assign dst_ev = sdram_dst &
    ((state == WAIT_DST) |
     ((state == WAIT_ACK) & sdram_ack));

  assign wr = dst_ev ? (3'b001 << sel) : 3'b000;

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    ftag_nx  = ftag;
    addr_nx  = sdram_addr;
    req_nx   = sdram_req;
    unique case (state)
      IDLE: begin
        if (|pend) begin
          sel_nx   = pick_idx;
          ftag_nx  = cli_addr[pick_idx];
          addr_nx  = base +
            SDRAM_AW'(cli_addr[pick_idx]);
          req_nx   = 1'b1;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          req_nx   = 1'b0;
          state_nx = sdram_dst ? IDLE : WAIT_DST;
        end
      end
      WAIT_DST: begin
        if (sdram_dst)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= CHAR;
      ftag       <= '0;
      sdram_addr <= '0;
      sdram_req  <= 1'b0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      ftag       <= ftag_nx;
      sdram_addr <= addr_nx;
      sdram_req  <= req_nx;
    end
  end

  jtkunio_gfx_slot #(.AW(14)) u_char (
    .clk     (clk),
    .rst     (rst),
    .cs      (char_cs),
    .addr    (char_addr),
    .wr      (wr[CHAR]),
    .wr_tag  (ftag[13:0]),
    .wr_data (sdram_data),
    .hit     (hit[CHAR]),
    .data    (char_data)
  );

  jtkunio_gfx_slot #(.AW(17)) u_scr (
    .clk     (clk),
    .rst     (rst),
    .cs      (scr_cs),
    .addr    (scr_addr),
    .wr      (wr[SCR]),
    .wr_tag  (ftag[16:0]),
    .wr_data (sdram_data),
    .hit     (hit[SCR]),
    .data    (scr_data)
  );

  jtkunio_gfx_slot #(.AW(18)) u_obj (
    .clk     (clk),
    .rst     (rst),
    .cs      (obj_cs),
    .addr    (obj_addr),
    .wr      (wr[OBJ]),
    .wr_tag  (ftag),
    .wr_data (sdram_data),
    .hit     (hit[OBJ]),
    .data    (obj_data)
  );

  assign char_ok = hit[CHAR];
  assign scr_ok  = hit[SCR];
  assign obj_ok  = hit[OBJ];

endmodule

// File: tb/tb_jtkunio_gfx_arb.sv
// Scoreboard bench for jtkunio_gfx_arb with a transaction-level
// cache/arbitration model and a randomised SDRAM responder.
module tb_jtkunio_gfx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        char_cs = 1'b0, scr_cs = 1'b0, obj_cs = 1'b0;
  logic [13:0] char_addr = '0;
  logic [16:0] scr_addr = '0;
  logic [17:0] obj_addr = '0;
  logic [31:0] char_data, scr_data, obj_data;
  logic        char_ok, scr_ok, obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0, sdram_dst = 1'b0;
  logic [31:0] sdram_data = '0;

  jtkunio_gfx_arb dut (
    .clk(clk), .rst(rst),
    .char_cs(char_cs), .char_addr(char_addr),
    .char_data(char_data), .char_ok(char_ok),
    .scr_cs(scr_cs), .scr_addr(scr_addr),
    .scr_data(scr_data), .scr_ok(scr_ok),
    .obj_cs(obj_cs), .obj_addr(obj_addr),
    .obj_data(obj_data), .obj_ok(obj_ok),
    .sdram_addr(sdram_addr), .sdram_req(sdram_req),
    .sdram_ack(sdram_ack), .sdram_dst(sdram_dst),
    .sdram_data(sdram_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  localparam logic [21:0] OFFS [3] =
    '{22'h0, 22'h4000, 22'h24000};

  // reference model: per-client cache + single outstanding read
  bit          mv [3];
  logic [17:0] mt [3];
  logic [31:0] md [3];
  int          mstate = 0;
  int          mg = 0;
  int          rr = 0;
  logic [17:0] mtag = '0;
  logic [21:0] maddr = '0;
  logic [21:0] exp_q [$];

  int          rsp_mode = 0;
  bit          rsp_fix = 0;
  logic [31:0] rsp_word = '0;
  bit          wait_dst = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s act=%h exp=%h t=%0t",
                 name, act, exp, $time);
    end
  endtask

  function automatic bit cs_of(int i);
    case (i)
      0: return char_cs;
      1: return scr_cs;
      default: return obj_cs;
    endcase
  endfunction

  function automatic logic [17:0] addr_of(int i);
    case (i)
      0: return {4'b0, char_addr};
      1: return {1'b0, scr_addr};
      default: return obj_addr;
    endcase
  endfunction

  function automatic bit exp_ok(int i);
    return cs_of(i) && mv[i] && (mt[i] == addr_of(i));
  endfunction

  function automatic int pick_m(logic [2:0] pend);
    int j;
`ifdef JTKUNIO_GFX_RR_EN
    for (int k = 0; k < 3; k++) begin
      j = (rr + k) % 3;
      if (pend[j]) return j;
    end
`else
    for (int k = 0; k < 3; k++) begin
      j = k;
      if (pend[j]) return j;
    end
`endif
    return 0;
  endfunction

  task automatic mdl_write();
    mv[mg] = 1;
    mt[mg] = mtag;
    md[mg] = sdram_data;
    mstate = 0;
  endtask

  always @(posedge clk) begin
    logic [2:0] pend;
    int g;
    #1;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mv[i] = 0; mt[i] = '0; md[i] = '0;
      end
      mstate = 0; mg = 0; rr = 0;
      mtag = '0; maddr = '0;
      exp_q.delete();
    end else begin
      case (mstate)
        0: begin
          for (int i = 0; i < 3; i++)
            pend[i] = cs_of(i) &&
              !(mv[i] && mt[i] == addr_of(i));
          if (pend != 3'b000) begin
            g = pick_m(pend);
            mg = g;
            mtag = addr_of(g);
            maddr = OFFS[g] + {4'b0, mtag};
            rr = (g + 1) % 3;
            mstate = 1;
            exp_q.push_back(maddr);
          end
        end
        1: if (sdram_ack) begin
          if (sdram_dst) mdl_write();
          else mstate = 2;
        end
        default: if (sdram_dst) mdl_write();
      endcase
    end
  end

  // monitor: pops expected grants when the DUT raises a request
  logic prev_req = 1'b0;
  always @(posedge clk) begin
    logic [21:0] e;
    #2;
    chk("sdram_req", 32'(sdram_req), 32'(mstate == 1));
    chk("sdram_addr", 32'(sdram_addr), 32'(maddr));
    if (sdram_req && !prev_req) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_req act=%h exp=none t=%0t",
                 sdram_addr, $time);
      end else begin
        e = exp_q.pop_front();
        chk("grant_addr", 32'(sdram_addr), 32'(e));
      end
    end
    prev_req = sdram_req;
    chk("char_ok", 32'(char_ok), 32'(exp_ok(0)));
    chk("scr_ok", 32'(scr_ok), 32'(exp_ok(1)));
    chk("obj_ok", 32'(obj_ok), 32'(exp_ok(2)));
    chk("char_data", char_data, md[0]);
    chk("scr_data", scr_data, md[1]);
    chk("obj_data", obj_data, md[2]);
  end

  // SDRAM responder
  always @(posedge clk) begin
    #4;
    sdram_ack = 1'b0;
    sdram_dst = 1'b0;
    sdram_data = rsp_fix ? rsp_word : $urandom;
    if (rst) begin
      wait_dst = 0;
    end else if (sdram_req && !wait_dst) begin
      case (rsp_mode)
        1: begin sdram_ack = 1'b1; sdram_dst = 1'b1; end
        2, 3: begin sdram_ack = 1'b1; wait_dst = 1; end
        default: if ($urandom_range(1, 0) == 1) begin
          sdram_ack = 1'b1;
          if ($urandom_range(2, 0) == 0) sdram_dst = 1'b1;
          else wait_dst = 1;
        end
      endcase
    end else if (wait_dst) begin
      if (rsp_mode == 3 ||
          (rsp_mode != 2 && $urandom_range(1, 0) == 1)) begin
        sdram_dst = 1'b1;
        wait_dst = 0;
      end
    end else if (!sdram_req) begin
      if (rsp_mode == 4 ||
          (rsp_mode == 0 && $urandom_range(7, 0) == 0))
        sdram_dst = 1'b1;
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #4;
    end
  endtask

  initial begin
    int n;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    rsp_mode = 1; rsp_fix = 1; rsp_word = 32'hDEADBEEF;
    cyc(1);
    char_cs = 1'b1; char_addr = 14'h0010;
    cyc(8);

    rsp_word = 32'h5C000005;
    cyc(1);
    scr_cs = 1'b1; scr_addr = 17'h00005;
    cyc(8);

    rsp_fix = 0;
    char_addr = 14'h0020; scr_addr = 17'h00006;
    obj_cs = 1'b1; obj_addr = 18'h00033;
    cyc(14);

    rsp_mode = 3;
    obj_addr = 18'h00040;
    n = 0;
    while (!sdram_req && n < 10) begin cyc(1); n++; end
    char_addr = 14'h0021;
    cyc(1);
    scr_addr = 17'h00007;
    cyc(16);

    obj_addr = 18'h00100;
    n = 0;
    while (!sdram_req && n < 10) begin cyc(1); n++; end
    if (!sdram_req) begin
      checks++; failures++;
      $display("FAIL obj_req_timeout act=0 exp=1");
    end
    obj_addr = 18'h00101;
    cyc(12);

    rsp_mode = 2;
    char_addr = 14'h0077;
    n = 0;
    while (mstate != 2 && n < 20) begin cyc(1); n++; end
    if (mstate != 2) begin
      checks++; failures++;
      $display("FAIL wait_dst_timeout act=%0d exp=2", mstate);
    end
    rst = 1'b1;
    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    #1;
    chk("rst_req", 32'(sdram_req), 32'd0);
    chk("rst_ok",
        32'({char_ok, scr_ok, obj_ok}), 32'd0);
    chk("rst_data", char_data | scr_data | obj_data, 32'd0);
    rsp_mode = 4;
    cyc(2);
    rst = 1'b0;
    cyc(6);

    rsp_mode = 0;
    for (int c = 0; c < 12; c++) begin
      obj_addr = 18'($urandom);
      cyc(1);
    end

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5, 0) == 0) begin
        char_cs = $urandom_range(3, 0) != 0;
        char_addr = 14'h10 + 14'($urandom_range(3, 0));
      end
      if ($urandom_range(5, 0) == 0) begin
        scr_cs = $urandom_range(3, 0) != 0;
        scr_addr = 17'h5 + 17'($urandom_range(3, 0));
      end
      if ($urandom_range(5, 0) == 0) begin
        obj_cs = $urandom_range(3, 0) != 0;
        obj_addr = ($urandom_range(9, 0) == 0) ?
          18'h3FFFF : 18'h100 + 18'($urandom_range(3, 0));
      end
      cyc(1);
    end

    char_cs = 1'b0; scr_cs = 1'b0; obj_cs = 1'b0;
    cyc(20);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
